// File: rtl/uart_cmd_ctrl.sv
// UART byte-frame command controller: decodes write/read frames into register-file
// strobes and returns read data as one byte on the transmit path.
module uart_cmd_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_WR     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD     = 8'hBB
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_DATA_VALID,
  input  logic                  PAR_ERR,
  input  logic                  STP_ERR,
  input  logic                  TX_Busy,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_DATA_VALID,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t state, state_nxt;

  logic                  accepted;
  logic                  rx_err;
  logic [DATA_WIDTH-1:0] tx_data_nxt;
  logic                  tx_valid_nxt;
  logic                  wr_en_nxt;
  logic                  rd_en_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;

  assign accepted = RX_DATA_VALID & ~PAR_ERR & ~STP_ERR;
  assign rx_err   = RX_DATA_VALID & (PAR_ERR | STP_ERR);

  // State and all outputs share one register stage so every output is registered.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      WrEn          <= 1'b0;
      RdEn          <= 1'b0;
      Address       <= '0;
      WrData        <= '0;
    end else begin
      state         <= state_nxt;
      TX_P_DATA     <= tx_data_nxt;
      TX_DATA_VALID <= tx_valid_nxt;
      WrEn          <= wr_en_nxt;
      RdEn          <= rd_en_nxt;
      Address       <= addr_nxt;
      WrData        <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accepted && RX_P_DATA == CMD_WR)      state_nxt = WR_ADDR;
        else if (accepted && RX_P_DATA == CMD_RD) state_nxt = RD_ADDR;
      end
      WR_ADDR: begin
        if (rx_err)        state_nxt = IDLE;
        else if (accepted) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        if (rx_err || accepted) state_nxt = IDLE;
      end
      RD_ADDR: begin
        if (rx_err)        state_nxt = IDLE;
        else if (accepted) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (RdData_Valid) state_nxt = TX_SEND;
      end
      TX_SEND: begin
        if (!TX_Busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next-value logic for the registered outputs; data registers hold by default.
  always_comb begin
    tx_data_nxt  = TX_P_DATA;
    tx_valid_nxt = 1'b0;
    wr_en_nxt    = 1'b0;
    rd_en_nxt    = 1'b0;
    addr_nxt     = Address;
    wr_data_nxt  = WrData;
    unique case (state)
      WR_ADDR: begin
        if (accepted) addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
      end
      WR_DATA: begin
        if (accepted) begin
          wr_data_nxt = RX_P_DATA;
          wr_en_nxt   = 1'b1;
        end
      end
      RD_ADDR: begin
        if (accepted) begin
          addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_nxt = 1'b1;
        end
      end
      RD_WAIT: begin
        if (RdData_Valid) tx_data_nxt = RdData;
      end
      TX_SEND: begin
        if (!TX_Busy) tx_valid_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected strobe events are queued as frames are
// driven, a monitor queues observed strobes, and each test task compares the two.
module tb_uart_cmd_ctrl;

  localparam logic [1:0] K_WR = 2'd1;
  localparam logic [1:0] K_RD = 2'd2;
  localparam logic [1:0] K_TX = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } evt_t;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] rd_data = '0;
  logic       rd_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] address;
  logic [7:0] wr_data;

  logic [31:0] cyc = '0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  evt_t exp_q[$];
  evt_t obs_q[$];
  evt_t e, o;

  uart_cmd_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .CMD_WR    (8'hAA),
    .CMD_RD    (8'hBB)
  ) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .RX_P_DATA    (rx_data),
    .RX_DATA_VALID(rx_valid),
    .PAR_ERR      (par_err),
    .STP_ERR      (stp_err),
    .TX_Busy      (tx_busy),
    .TX_P_DATA    (tx_data),
    .TX_DATA_VALID(tx_valid),
    .WrEn         (wr_en),
    .RdEn         (rd_en),
    .Address      (address),
    .WrData       (wr_data),
    .RdData       (rd_data),
    .RdData_Valid (rd_valid)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every strobe cycle becomes one observed event stamped with the cycle count.
  always @(negedge CLK) begin
    if (rst_n) begin
      if (wr_en)    obs_q.push_back({K_WR, address, wr_data, cyc});
      if (rd_en)    obs_q.push_back({K_RD, address, 8'h00, cyc});
      if (tx_valid) obs_q.push_back({K_TX, 4'h0, tx_data, cyc});
      if (wr_en || rd_en || tx_valid) begin
        tests++;
        if ({1'b0, wr_en} + {1'b0, rd_en} + {1'b0, tx_valid} > 2'd1) begin
          fails++;
          $display("FAIL strobe_overlap: got WrEn=%0b RdEn=%0b TXV=%0b, expected at most one high",
                   wr_en, rd_en, tx_valid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Inputs change right after a falling edge; the byte is sampled on the next rising edge
  // and the task returns at the following falling edge, when registered outputs are visible.
  task automatic send_byte(input logic [7:0] b, input logic par, input logic stp);
    rx_data  = b;
    rx_valid = 1'b1;
    par_err  = par;
    stp_err  = stp;
    @(negedge CLK);
  endtask

  task automatic rx_clear;
    rx_valid = 1'b0;
    par_err  = 1'b0;
    stp_err  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    tests++;
    if ({tx_data, tx_valid, wr_en, rd_en, address, wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_values: got TX_P_DATA=%h TXV=%b WrEn=%b RdEn=%b Address=%h WrData=%h, expected all 0",
               tx_data, tx_valid, wr_en, rd_en, address, wr_data);
    end
    rst_n = 1'b1;
    @(negedge CLK);
    obs_q.delete();
  endtask

  task automatic test_write;
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h5C, 1'b0, 1'b0);
    exp_q.push_back({K_WR, 4'h3, 8'h5C, cyc});
    rx_clear();
    repeat (4) @(negedge CLK);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL write_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL write_evt: got kind=%0d addr=%h data=%h cyc=%0d, expected kind=%0d addr=%h data=%h cyc=%0d",
                 o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_read(input int unsigned busy_cycles, input logic [7:0] val);
    tx_busy = (busy_cycles > 0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'h07, 1'b0, 1'b0);
    exp_q.push_back({K_RD, 4'h7, 8'h00, cyc});
    rx_clear();
    @(negedge CLK);
    send_byte(8'hAA, 1'b0, 1'b0);   // arrives while waiting for read data; must be ignored
    rx_clear();
    rd_data  = val;
    rd_valid = 1'b1;
    @(negedge CLK);
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    tests++;
    if (tx_data !== val) begin
      fails++;
      $display("FAIL read_capture: got TX_P_DATA=%h, expected %h", tx_data, val);
    end
    if (busy_cycles > 0) begin
      send_byte(8'hBB, 1'b0, 1'b0); // ignored while holding in TX_SEND
      rx_clear();
      repeat (busy_cycles) @(negedge CLK);
      tx_busy = 1'b0;
    end
    exp_q.push_back({K_TX, 4'h0, val, cyc + 1});
    repeat (5) @(negedge CLK);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL read_count(busy=%0d): got %0d events, expected %0d", busy_cycles, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL read_evt(busy=%0d): got kind=%0d addr=%h data=%h cyc=%0d, expected kind=%0d addr=%h data=%h cyc=%0d",
                 busy_cycles, o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_error_abort;
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h5C, 1'b0, 1'b0);
    rx_clear();
    @(negedge CLK);
    tests++;
    if (address !== 4'h7) begin
      fails++;
      $display("FAIL abort_par_addr: got Address=%h, expected 7 (held)", address);
    end
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h5C, 1'b0, 1'b1);
    rx_clear();
    repeat (4) @(negedge CLK);
    tests++;
    if (address !== 4'h3 || wr_data !== 8'h5C) begin
      fails++;
      $display("FAIL abort_stp_regs: got Address=%h WrData=%h, expected 3 and 5c (held)", address, wr_data);
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL abort_count: got %0d events, expected 0", obs_q.size());
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    exp_q.push_back({K_WR, 4'h1, 8'h11, cyc});
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    exp_q.push_back({K_WR, 4'h2, 8'h22, cyc});
    rx_clear();
    repeat (4) @(negedge CLK);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL b2b_evt: got kind=%0d addr=%h data=%h cyc=%0d, expected kind=%0d addr=%h data=%h cyc=%0d",
                 o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0);
    rx_clear();
    tests++;
    if (address !== 4'h4) begin
      fails++;
      $display("FAIL midrst_pre_addr: got Address=%h, expected 4", address);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({tx_data, tx_valid, wr_en, rd_en, address, wr_data} !== '0) begin
      fails++;
      $display("FAIL midrst_async: got TX_P_DATA=%h TXV=%b WrEn=%b RdEn=%b Address=%h WrData=%h, expected all 0",
               tx_data, tx_valid, wr_en, rd_en, address, wr_data);
    end
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    send_byte(8'h5C, 1'b0, 1'b0);
    rx_clear();
    repeat (3) @(negedge CLK);
    tests++;
    if (address !== 4'h0 || wr_data !== 8'h00) begin
      fails++;
      $display("FAIL midrst_post_regs: got Address=%h WrData=%h, expected 0 and 00", address, wr_data);
    end
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h09, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    exp_q.push_back({K_WR, 4'h9, 8'h3C, cyc});
    rx_clear();
    repeat (4) @(negedge CLK);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL midrst_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL midrst_evt: got kind=%0d addr=%h data=%h cyc=%0d, expected kind=%0d addr=%h data=%h cyc=%0d",
                 o.kind, o.addr, o.data, o.cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(0, 8'hE1);
    test_read(20, 8'h5A);
    test_error_abort();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
